// File: rtl/wb_rr_arbiter.sv
`timescale 1ns/1ps
// wb_rr_arbiter: round-robin Wishbone classic arbiter for NM masters
// (0 = CPU, 1 = AUX, 2 = SPI) sharing one slave bus. A watchdog ends a
// stalled bus cycle with a synthesized ack that carries ERR_DATA.
module wb_rr_arbiter #(
  parameter int          NM       = 3,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hdeaddead
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [NM-1:0]     m_cyc,
  input  logic [NM-1:0]     m_stb,
  input  logic [NM-1:0]     m_we,
  input  logic [4*NM-1:0]   m_sel,
  input  logic [32*NM-1:0]  m_adr,
  input  logic [32*NM-1:0]  m_dat,
  output logic [NM-1:0]     m_ack,
  output logic [31:0]       m_rdt,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [3:0]        s_sel,
  output logic [31:0]       s_adr,
  output logic [31:0]       s_dat,
  input  logic              s_ack,
  input  logic [31:0]       s_rdt,
  output logic [NM-1:0]     busid,
  output logic              to_evt,
  output logic [7:0]        to_cnt
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;

  // Watchdog compares against the last count before expiry.
  localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [7:0]    wdt;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          wdt_fire;

  // Round-robin search: first requester after the last winner.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NM; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last) + k) % NM);
      if (!win_found && m_cyc[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Bus routing: AND-OR mux driven by the one-hot grant; all zero when idle.
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_sel = '0;
    s_adr = '0;
    s_dat = '0;
    for (int i = 0; i < NM; i++) begin
      if (busid[i]) begin
        s_cyc = m_cyc[i];
        s_stb = m_stb[i];
        s_we  = m_we[i];
        s_sel = m_sel[4*i +: 4];
        s_adr = m_adr[32*i +: 32];
        s_dat = m_dat[32*i +: 32];
      end
    end
  end

  // Watchdog expiry and the ack/read-data return path. A real ack in the
  // expiry cycle wins over the watchdog.
  always_comb begin
    wdt_fire = (state == ST_GRANT) && (wdt == WDT_LAST) && s_stb && !s_ack;
    m_ack    = busid & {NM{s_ack | wdt_fire}};
    m_rdt    = wdt_fire ? ERR_DATA : s_rdt;
  end

  // Grant FSM: one idle cycle between grants, grant held while cyc is high.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state <= ST_IDLE;
      busid <= '0;
      last  <= IW'(NM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            busid <= NM'(1) << win_idx;
            last  <= win_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!s_cyc) begin
            busid <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busid <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Watchdog counter, termination pulse and saturating termination count.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wdt    <= '0;
      to_evt <= 1'b0;
      to_cnt <= '0;
    end else begin
      to_evt <= wdt_fire;
      if ((state != ST_GRANT) || !s_stb || s_ack || wdt_fire) begin
        wdt <= '0;
      end else begin
        wdt <= wdt + 8'd1;
      end
      if (wdt_fire && (to_cnt != 8'hff)) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for wb_rr_arbiter: round-robin order, single read,
// watchdog expiry, ack-at-expiry, reset mid-grant and counter saturation.
module tb_wb_rr_arbiter;

  localparam int NM = 3;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [4*NM-1:0]   m_sel;
  logic [32*NM-1:0]  m_adr, m_dat;
  logic [NM-1:0]     m_ack;
  logic [31:0]       m_rdt;
  logic              s_cyc, s_stb, s_we;
  logic [3:0]        s_sel;
  logic [31:0]       s_adr, s_dat;
  logic              s_ack;
  logic [31:0]       s_rdt;
  logic [NM-1:0]     busid;
  logic              to_evt;
  logic [7:0]        to_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int evt_seen;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(64), .ERR_DATA(32'hdeaddead)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat(m_dat), .m_ack(m_ack), .m_rdt(m_rdt),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat(s_dat), .s_ack(s_ack), .s_rdt(s_rdt),
    .busid(busid), .to_evt(to_evt), .to_cnt(to_cnt)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven and outputs sampled here.
  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    return 32'h1000_0000 + 32'(idx * 16);
  endfunction

  // One round-robin transfer by master idx, then its idle cycle and re-request.
  task automatic rr_xfer(input int idx);
    check("rr_busid", 32'(busid), 32'(1 << idx));
    check("rr_adr", s_adr, addr_of(idx));
    s_ack = 1'b1;
    s_rdt = 32'h0000_0a00 + 32'(idx);
    #1;
    check("rr_ack", 32'(m_ack), 32'(1 << idx));
    step();
    s_ack = 1'b0;
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
    #1;
    check("rr_ack_low", 32'(m_ack), 32'h0);
    step();
    check("rr_idle_gap", 32'(busid), 32'h0);
    m_cyc[idx] = 1'b1;
    m_stb[idx] = 1'b1;
    step();
  endtask

  initial begin
    wb_rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1;
    m_adr = {addr_of(2), addr_of(1), addr_of(0)};
    m_dat = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    s_ack = 1'b0; s_rdt = '0;
    step(); step();

    // Reset state
    check("rst_busid", 32'(busid), 32'h0);
    check("rst_to_cnt", 32'(to_cnt), 32'h0);
    check("rst_to_evt", 32'(to_evt), 32'h0);
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_m_ack", 32'(m_ack), 32'h0);
    wb_rst_n = 1'b1;
    step();

    // Round robin: all three request, order 0,1,2,0
    m_cyc = 3'b111; m_stb = 3'b111;
    step();
    rr_xfer(0);
    rr_xfer(1);
    rr_xfer(2);
    rr_xfer(0);
    m_cyc = '0; m_stb = '0;
    step();
    check("rr_release", 32'(busid), 32'h0);
    step();

    // Single SPI read, slave acks two cycles after stb
    m_cyc = 3'b100; m_stb = 3'b100; m_we = '0;
    step();
    check("spi_busid", 32'(busid), 32'h4);
    check("spi_s_stb", 32'(s_stb), 32'h1);
    step();
    check("spi_wait_ack", 32'(m_ack), 32'h0);
    step();
    s_ack = 1'b1; s_rdt = 32'h1234_5678;
    #1;
    check("spi_ack", 32'(m_ack), 32'h4);
    check("spi_rdt", m_rdt, 32'h1234_5678);
    step();
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    #1;
    check("spi_ack_done", 32'(m_ack), 32'h0);
    step(); step();

    // Watchdog: master 0 strobes, slave never acks
    m_adr[31:0] = 32'h0080_0000;
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    check("wdt_adr", s_adr, 32'h0080_0000);
    for (int k = 1; k < 64; k++) begin
      if (k == 1 || k == 63) check("wdt_no_early_ack", 32'(m_ack), 32'h0);
      step();
    end
    check("wdt_ack", 32'(m_ack), 32'h1);
    check("wdt_rdt", m_rdt, 32'hdeaddead);
    check("wdt_evt_pre", 32'(to_evt), 32'h0);
    step();
    check("wdt_evt", 32'(to_evt), 32'h1);
    check("wdt_cnt", 32'(to_cnt), 32'h1);
    check("wdt_ack_after", 32'(m_ack), 32'h0);
    step();
    check("wdt_evt_once", 32'(to_evt), 32'h0);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Real ack in the expiry cycle wins
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    for (int k = 1; k < 64; k++) step();
    s_ack = 1'b1; s_rdt = 32'hcafe_f00d;
    #1;
    check("coin_ack", 32'(m_ack), 32'h1);
    check("coin_rdt", m_rdt, 32'hcafe_f00d);
    step();
    s_ack = 1'b0;
    check("coin_no_evt", 32'(to_evt), 32'h0);
    check("coin_cnt", 32'(to_cnt), 32'h1);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Reset mid-grant with master 1 strobing
    m_cyc = 3'b010; m_stb = 3'b010;
    step();
    check("mid_busid", 32'(busid), 32'h2);
    step();
    wb_rst_n = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b111;
    step();
    s_ack = 1'b1;
    #1;
    check("mid_rst_busid", 32'(busid), 32'h0);
    check("mid_rst_s_cyc", 32'(s_cyc), 32'h0);
    check("mid_rst_no_ack", 32'(m_ack), 32'h0);
    check("mid_rst_cnt", 32'(to_cnt), 32'h0);
    wb_rst_n = 1'b1;
    s_ack = 1'b0;
    step();
    check("mid_first_grant", 32'(busid), 32'h1);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // 300 timeouts: to_cnt saturates at 255
    m_cyc = 3'b001; m_stb = 3'b001;
    evt_seen = 0;
    step();
    for (int i = 1; i <= 300 * 64 + 10; i++) begin
      if (to_evt) evt_seen++;
      step();
    end
    check("sat_evt_count", 32'(evt_seen), 32'd300);
    check("sat_to_cnt", 32'(to_cnt), 32'd255);
    m_cyc = '0; m_stb = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Wishbone classic bus arbiter that shares the single SoC bus (block RAM + GPIO address decoder) among NM masters: CPU, AUX CPU and SPI bridge.
- Round-robin grant replaces the fixed-priority grant, so the SPI loader cannot be starved by two running CPUs.
- Includes the bus-cycle watchdog: a stalled slave is terminated with a synthesized ack carrying 32'hdeaddead.
- Sits between the masters and the address decoder, one level above it.

Parameters:
- NM, 3, number of masters; index 0 = CPU, 1 = AUX, 2 = SPI.
- TIMEOUT, 64, consecutive unacked strobe cycles before the watchdog fires; legal range 2..255.
- ERR_DATA, 32'hdeaddead, read data returned on a watchdog ack.

Ports:
- wb_clk  in  1  clock.
- wb_rst_n  in  1  synchronous, active-low reset.
- m_cyc  in  NM  per-master cyc.
- m_stb  in  NM  per-master stb.
- m_we  in  NM  per-master we.
- m_sel  in  4*NM  per-master sel; master i at [4i+3:4i].
- m_adr  in  32*NM  per-master address; slice [32i+31:32i].
- m_dat  in  32*NM  per-master write data.
- m_ack  out  NM  per-master ack.
- m_rdt  out  32  read data, shared by all masters.
- s_cyc  out  1  bus cyc.
- s_stb  out  1  bus stb.
- s_we  out  1  bus we.
- s_sel  out  4  bus sel.
- s_adr  out  32  bus address.
- s_dat  out  32  bus write data.
- s_ack  in  1  bus ack.
- s_rdt  in  32  bus read data.
- busid  out  NM  one-hot granted master; 0 when idle.
- to_evt  out  1  one-cycle pulse on a watchdog termination.
- to_cnt  out  8  saturating count of watchdog terminations.

Behaviour:
Reset (wb_rst_n low at a clock edge):
- state=IDLE, busid=0, last=NM-1 (so master 0 wins first), wdt=0, to_evt=0, to_cnt=0.
- All s_* outputs and all m_ack are 0 combinationally while busid=0.
- Reset mid-transfer drops the grant immediately. No ack is issued to the interrupted master.

State machine:
- IDLE: if any m_cyc is set, grant the first requester searching (last+1), (last+2), ... mod NM. At the edge: busid = onehot(winner), last = winner, state = GRANT. Grant latency is 1 cycle from cyc to busid.
- GRANT: hold the grant while m_cyc[g] = 1. When m_cyc[g] = 0 at an edge: state = IDLE, busid = 0. There is at least one idle cycle between grants; no back-to-back re-grant in the same cycle.
- Any other state encoding: go to IDLE.

Routing (combinational):
- s_cyc = m_cyc[g] & grant, and s_stb = m_stb[g] & grant. we, sel, adr and dat come from master g; all are 0 when idle.
- m_ack[i] = grant[i] & (s_ack | wdt_fire).
- m_rdt = wdt_fire ? ERR_DATA : s_rdt.

Watchdog:
- wdt is an 8-bit counter. It clears when not in GRANT, when s_stb = 0, or when s_ack = 1; otherwise it increments.
- wdt_fire = (wdt == TIMEOUT-1) & s_stb & ~s_ack. The ack goes out in the TIMEOUT-th consecutive unacked strobe cycle.
- On the edge after wdt_fire: wdt = 0, to_evt = 1 for exactly one cycle, to_cnt += 1, saturating at 255.
- If s_ack and the expiry coincide, the real ack wins: no fire, no to_evt, and m_rdt = s_rdt.
- A master that drops cyc before expiry clears wdt with no event.

Other rules:
- Only the granted master ever sees an ack. Non-granted masters wait with cyc held high.
- Round-robin fairness: with all NM masters requesting continuously and releasing after one transfer each, grant order is 0, 1, 2, 0, ...

Test Plan:
- Reset release, then m_cyc=3'b111 held: busid goes 001, then after master 0 drops cyc and one idle cycle, 010, then 100, then 001; each master sees exactly one ack per transfer.
- Single master 2 (SPI) read, slave acks 2 cycles after stb with s_rdt=32'h12345678: busid=100 one cycle after cyc, m_ack=3'b100 for 1 cycle, m_rdt=32'h12345678, other m_ack stay 0.
- Master 0 strobes address 32'h00800000 and the slave never acks, TIMEOUT=64: m_ack[0]=1 in the 64th strobe cycle with m_rdt=32'hdeaddead, to_evt pulses once, to_cnt=1.
- Slave acks in exactly the expiry cycle (cycle 64): m_rdt=s_rdt, to_evt stays 0, to_cnt unchanged.
- wb_rst_n pulled low for 1 cycle mid-grant with master 1 strobing: next cycle busid=0, s_cyc=0, no ack to master 1, and with all requesting master 0 is granted first.
- Force 300 watchdog timeouts: to_cnt saturates at 8'd255 and does not wrap.
